// File: rtl/fifo_frame_loader_if.sv
// Handshake bundle for fifo_frame_loader: FIFO read port, sample stream
// towards the FFT input stage, and frame status.
// master = the frame loader itself, slave = whatever sits around it.
interface fifo_frame_loader_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
);
    logic                  Enable_in;
    logic [DATA_WIDTH-1:0] FifoData_in;
    logic                  FifoEmpty_in;
    logic                  FifoReadEn_out;
    logic [DATA_WIDTH-1:0] Sample_out;
    logic                  Valid_out;
    logic                  Ready_in;
    logic                  Sop_out;
    logic                  Eop_out;
    logic                  FrameDone_out;
    logic [CNT_WIDTH-1:0]  FrameCount_out;
    logic                  Busy_out;

    modport master (
        input  Enable_in, FifoData_in, FifoEmpty_in, Ready_in,
        output FifoReadEn_out, Sample_out, Valid_out, Sop_out, Eop_out,
               FrameDone_out, FrameCount_out, Busy_out
    );

    modport slave (
        output Enable_in, FifoData_in, FifoEmpty_in, Ready_in,
        input  FifoReadEn_out, Sample_out, Valid_out, Sop_out, Eop_out,
               FrameDone_out, FrameCount_out, Busy_out
    );
endinterface

// File: rtl/fifo_frame_loader.sv
// fifo_frame_loader: pops PCM samples from the audio FIFO (registered read
// data, one cycle after the pop), groups them into FRAME_LEN-sample frames and
// streams them out over valid/ready with Sop/Eop markers.
// Optional macro FRAME_LOADER_DECIM2_EN: pop every word but forward only the
// even ones, so each frame consumes 2*FRAME_LEN FIFO words.
module fifo_frame_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAME_LEN  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input logic                Clk,
    input logic                Reset_in,
    fifo_frame_loader_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Index can reach FRAME_LEN in decimating mode (after the last kept sample)
    localparam int               IDX_W    = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] sample_q;
    logic                  valid_q;
    logic                  sop_q;
    logic                  eop_q;
    logic [CNT_WIDTH-1:0]  count_q;

    logic pop;
    logic capture;
    logic lastPop;
    logic frameIdle;

    // A pop waits for the previous word to land and for the output register to be free
    assign pop = (state_q == STREAM) & ~bus.FifoEmpty_in & ~inflight_q
               & (~valid_q | bus.Ready_in);

    // IDLE and DONE are the only places a frame boundary happens
    assign frameIdle = (state_q == IDLE) | (state_q == DONE);

`ifdef FRAME_LOADER_DECIM2_EN
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(FRAME_LEN);

    logic toggle_q, toggle_d;
    logic keep_q;

    // The last pop of a frame is the discarded odd word after the final kept sample
    assign capture = inflight_q & keep_q;
    assign lastPop = pop & toggle_q & (index_q == FULL_IDX);

    // Parity of popped words, restarted at every frame boundary
    always_comb begin
        toggle_d = toggle_q;
        if (frameIdle)
            toggle_d = 1'b0;
        else if (pop)
            toggle_d = ~toggle_q;
    end

    // Parity register plus the keep/discard mark carried alongside the in-flight word
    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            toggle_q <= 1'b0;
            keep_q   <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
            if (pop)
                keep_q <= ~toggle_q;
        end
    end
`else
    assign capture = inflight_q;
    assign lastPop = pop & (index_q == LAST_IDX);
`endif

    // Frame sequencing; a mid-frame Enable drop lets the current frame finish
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Enable_in) state_d = STREAM;
            STREAM:  if (lastPop) state_d = DRAIN;
            DRAIN:   if (~inflight_q & (~valid_q | bus.Ready_in)) state_d = DONE;
            DONE:    state_d = bus.Enable_in ? STREAM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample index counts captured samples and only returns to zero between frames
    always_comb begin
        index_d = index_q;
        if (frameIdle)
            index_d = '0;
        else if (capture)
            index_d = index_q + IDX_W'(1);
    end

    // Control state and the one-cycle in-flight marker for registered FIFO data
    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            state_q    <= IDLE;
            index_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            inflight_q <= pop;
        end
    end

    // Output register: load on capture, hold under backpressure, clear after handshake
    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
        end else if (capture) begin
            sample_q <= bus.FifoData_in;
            valid_q  <= 1'b1;
            sop_q    <= (index_q == '0);
            eop_q    <= (index_q == LAST_IDX);
        end else if (valid_q & bus.Ready_in) begin
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
        end
    end

    // Completed-frame counter, wrapping naturally at its width
    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in)
            count_q <= '0;
        else if (state_q == DONE)
            count_q <= count_q + CNT_WIDTH'(1);
    end

    assign bus.FifoReadEn_out = pop;
    assign bus.Sample_out     = sample_q;
    assign bus.Valid_out      = valid_q;
    assign bus.Sop_out        = sop_q;
    assign bus.Eop_out        = eop_q;
    assign bus.FrameDone_out  = (state_q == DONE);
    assign bus.FrameCount_out = count_q;
    assign bus.Busy_out       = (state_q != IDLE);
endmodule
